// File: rtl/dac_update_scheduler_pkg.sv
// Shared definitions for the SPGD DAC update scheduler.
//   DAC_WIDTH        default DAC data width
//   OFFSET_MIDSCALE  offset-binary midscale code for the default width
//   state_t          scheduler FSM states
//   req_idx_width()  width of a requester index for a given requester count
package spgd_dac_pkg;

    localparam int DAC_WIDTH = 14;
    localparam logic [DAC_WIDTH-1:0] OFFSET_MIDSCALE = 14'h2000;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        LOAD,
        SETTLE,
        ACK
    } state_t;

    // A single requester still needs a 1-bit select.
    function automatic int req_idx_width(input int n_req);
        return (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

endpackage

// File: rtl/dac_update_scheduler_if.sv
// Requester/DAC bundle of the DAC update scheduler.
//   req        per-requester update request (level, held until ack)
//   data_in    packed offset-binary codes, requester i at [i*W +: W]
//   ack        one-cycle pulse to the served requester
//   dac_data   two's-complement code to the DAC register
//   dac_valid  one-cycle strobe when dac_data is loaded
//   dac_sel    index of the granted requester
//   busy       scheduler not idle
// master: requester/DAC side; slave: the scheduler.
interface dac_update_scheduler_if
    import spgd_dac_pkg::*;
#(
    parameter int WIRE_WIDTH = DAC_WIDTH,
    parameter int N_REQ      = 4
);
    localparam int SEL_W = req_idx_width(N_REQ);

    logic [N_REQ-1:0]            req;
    logic [N_REQ*WIRE_WIDTH-1:0] data_in;
    logic [N_REQ-1:0]            ack;
    logic [WIRE_WIDTH-1:0]       dac_data;
    logic                        dac_valid;
    logic [SEL_W-1:0]            dac_sel;
    logic                        busy;

    modport master (
        output req, data_in,
        input  ack, dac_data, dac_valid, dac_sel, busy
    );

    modport slave (
        input  req, data_in,
        output ack, dac_data, dac_valid, dac_sel, busy
    );

endinterface

// File: rtl/dac_update_scheduler_offset_to_twos.sv
// Offset-binary to two's-complement converter (pure combinational).
//   offset_code  offset-binary input code
//   twos_code    same value in two's complement (MSB inverted)
module offset_to_twos #(
    parameter int WIRE_WIDTH = 14
) (
    input  logic [WIRE_WIDTH-1:0] offset_code,
    output logic [WIRE_WIDTH-1:0] twos_code
);

    assign twos_code = {~offset_code[WIRE_WIDTH-1], offset_code[WIRE_WIDTH-2:0]};

endmodule

// File: rtl/dac_update_scheduler.sv
// Round-robin scheduler sharing one DAC channel between N_REQ SPGD requesters.
// The winner's offset-binary code is converted to two's complement, driven to
// the DAC with a dac_valid strobe, held for SETTLE_CYCLES, then acknowledged.
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    dac_update_scheduler_if.slave (req/data_in in; ack, dac_data,
//          dac_valid, dac_sel, busy out)
// Optional build macro DAC_SLEW_LIMIT_EN: each LOAD moves the output at most
// MAX_STEP offset-binary LSBs toward the target, re-settling after every step;
// ack is issued only once the target is reached.
module dac_update_scheduler
    import spgd_dac_pkg::*;
#(
    parameter int                    WIRE_WIDTH    = DAC_WIDTH,
    parameter int                    N_REQ         = 4,
    parameter int                    SETTLE_CYCLES = 16,
    parameter logic [WIRE_WIDTH-1:0] MAX_STEP      = 'h0100
) (
    input  logic                   clk,
    input  logic                   rst_n,
    dac_update_scheduler_if.slave  bus
);

    localparam int SEL_W = req_idx_width(N_REQ);
    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [WIRE_WIDTH-1:0] MIDSCALE =
        (WIRE_WIDTH == DAC_WIDTH) ? WIRE_WIDTH'(OFFSET_MIDSCALE)
                                  : {1'b1, {(WIRE_WIDTH-1){1'b0}}};

    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
        $error("dac_update_scheduler: N_REQ must be 2..8");
    end
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("dac_update_scheduler: SETTLE_CYCLES must be >= 1");
    end
    if (MAX_STEP == '0) begin : g_bad_step
        $error("dac_update_scheduler: MAX_STEP must be non-zero");
    end

    state_t                state;
    logic [SEL_W-1:0]      ptr;
    logic [SEL_W-1:0]      dac_sel;
    logic [WIRE_WIDTH-1:0] target;
    logic [WIRE_WIDTH-1:0] last_code;
    logic [WIRE_WIDTH-1:0] dac_data;
    logic                  dac_valid;
    logic [N_REQ-1:0]      ack;
    logic                  busy;
    logic [CNT_W-1:0]      cnt;

    logic [WIRE_WIDTH-1:0] req_code [N_REQ];
    logic                  grant_found;
    logic [SEL_W-1:0]      grant_idx;
    logic [SEL_W-1:0]      cand_idx;
    int                    cand;
    logic [WIRE_WIDTH-1:0] next_code;
    logic [WIRE_WIDTH-1:0] load_code;

    for (genvar i = 0; i < N_REQ; i++) begin : g_split
        assign req_code[i] = bus.data_in[i*WIRE_WIDTH +: WIRE_WIDTH];
    end

    // Round-robin pick: first asserted req at or after ptr, wrapping.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= N_REQ) cand = cand - N_REQ;
            cand_idx = SEL_W'(cand);
            if (!grant_found && bus.req[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // Code applied by the next LOAD, in offset binary.
    always_comb begin
        next_code = target;
`ifdef DAC_SLEW_LIMIT_EN
        // Clamping to the target means a step can never overshoot or wrap.
        if (target > last_code) begin
            if ((target - last_code) > MAX_STEP) next_code = last_code + MAX_STEP;
        end else begin
            if ((last_code - target) > MAX_STEP) next_code = last_code - MAX_STEP;
        end
`endif
    end

    offset_to_twos #(.WIRE_WIDTH(WIRE_WIDTH)) u_conv (
        .offset_code (next_code),
        .twos_code   (load_code)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            dac_sel   <= '0;
            target    <= MIDSCALE;
            last_code <= MIDSCALE;
            dac_data  <= '0;
            dac_valid <= 1'b0;
            ack       <= '0;
            busy      <= 1'b0;
            cnt       <= '0;
        end else begin
            dac_valid <= 1'b0;
            ack       <= '0;
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        state <= GRANT;
                        busy  <= 1'b1;
                    end
                end
                GRANT: begin
                    // A requester that withdrew before this cycle is not served.
                    if (grant_found) begin
                        dac_sel <= grant_idx;
                        target  <= req_code[grant_idx];
                        state   <= LOAD;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                LOAD: begin
                    last_code <= next_code;
                    dac_data  <= load_code;
                    dac_valid <= 1'b1;
                    cnt       <= CNT_W'(SETTLE_CYCLES - 1);
                    state     <= SETTLE;
                end
                SETTLE: begin
                    if (cnt == '0) begin
                        // Without slew limiting last_code always equals target here.
                        if (last_code == target) begin
                            ack   <= N_REQ'(1) << dac_sel;
                            state <= ACK;
                        end else begin
                            state <= LOAD;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ACK: begin
                    ptr   <= (dac_sel == SEL_W'(N_REQ - 1)) ? '0 : dac_sel + 1'b1;
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ack       = ack;
    assign bus.dac_data  = dac_data;
    assign bus.dac_valid = dac_valid;
    assign bus.dac_sel   = dac_sel;
    assign bus.busy      = busy;

endmodule

// File: tb/tb_dac_update_scheduler.sv
// Directed self-checking bench for dac_update_scheduler (N_REQ=4,
// SETTLE_CYCLES=16). The slew-limit scenario runs when DAC_SLEW_LIMIT_EN is
// defined; otherwise the full-step scenarios run.
module tb_dac_update_scheduler;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   ack_count;
    int   valid_count;

    dac_update_scheduler_if #(.WIRE_WIDTH(14), .N_REQ(4)) bus ();

    dac_update_scheduler #(
        .WIRE_WIDTH    (14),
        .N_REQ         (4),
        .SETTLE_CYCLES (16),
        .MAX_STEP      (14'h0100)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Event counters sampled mid-cycle, away from both edges used by stimulus.
    initial begin
        ack_count   = 0;
        valid_count = 0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.ack !== 4'b0000) ack_count++;
            if (bus.dac_valid === 1'b1) valid_count++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic set_code(input int i, input logic [13:0] v);
        bus.data_in[i*14 +: 14] = v;
    endtask

    task automatic wait_valid(input string tag, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.dac_valid !== 1'b1 && n < 60);
        check({tag, " valid seen"}, 32'(bus.dac_valid), 32'd1);
    endtask

    task automatic wait_ack(input string tag, input int exp_sel);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.ack === 4'b0000 && n < 60);
        check({tag, " settle cycles"}, n, 32'd16);
        check({tag, " ack"}, 32'(bus.ack), 32'(1) << exp_sel);
    endtask

    task automatic serve(input string tag, input int exp_sel, input logic [13:0] exp_code);
        int n;
        wait_valid(tag, n);
        check({tag, " sel"}, 32'(bus.dac_sel), exp_sel);
        check({tag, " data"}, 32'(bus.dac_data), 32'(exp_code));
        wait_ack(tag, exp_sel);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int snap;
        int n;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.req     = '0;
        bus.data_in = '0;

        // 1. Reset values and no activity without requests.
        tick();
        tick();
        check("rst dac_data", 32'(bus.dac_data), 32'h0);
        check("rst dac_valid", 32'(bus.dac_valid), 32'h0);
        check("rst ack", 32'(bus.ack), 32'h0);
        check("rst busy", 32'(bus.busy), 32'h0);
        check("rst dac_sel", 32'(bus.dac_sel), 32'h0);
        rst_n = 1'b1;
        snap = valid_count;
        repeat (10) tick();
        check("idle no valid", valid_count - snap, 32'd0);
        check("idle busy", 32'(bus.busy), 32'h0);

`ifdef DAC_SLEW_LIMIT_EN
        // 6. Slew-limited move from midscale to 14'h2300 in three steps.
        do_reset();
        set_code(0, 14'h2300);
        bus.req = 4'b0001;
        snap = ack_count;
        wait_valid("slew step1", n);
        check("slew step1 data", 32'(bus.dac_data), 32'h0100);
        wait_valid("slew step2", n);
        check("slew step2 spacing", n, 32'd17);
        check("slew step2 data", 32'(bus.dac_data), 32'h0200);
        wait_valid("slew step3", n);
        check("slew step3 spacing", n, 32'd17);
        check("slew step3 data", 32'(bus.dac_data), 32'h0300);
        check("slew no early ack", ack_count - snap, 32'd0);
        wait_ack("slew", 0);
        bus.req = 4'b0000;
        tick();
        check("slew ack single pulse", 32'(bus.ack), 32'h0);
        check("slew ack count", ack_count - snap, 32'd1);
`else
        // 2. Single request on requester 1, exact latencies.
        set_code(1, 14'h0000);
        bus.req = 4'b0010;
        tick();
        tick();
        check("single no early valid", 32'(bus.dac_valid), 32'h0);
        check("single busy", 32'(bus.busy), 32'h1);
        tick();
        check("single valid at 3", 32'(bus.dac_valid), 32'h1);
        check("single data", 32'(bus.dac_data), 32'h2000);
        check("single sel", 32'(bus.dac_sel), 32'h1);
        wait_ack("single", 1);
        bus.req = 4'b0000;
        tick();
        check("single ack one cycle", 32'(bus.ack), 32'h0);
        check("single back idle", 32'(bus.busy), 32'h0);

        // 3. All requests at once from a fresh pointer: order 0,1,2,3,0.
        do_reset();
        set_code(0, 14'h0001);
        set_code(1, 14'h1FFF);
        set_code(2, 14'h2000);
        set_code(3, 14'h3FFF);
        bus.req = 4'b1111;
        serve("rr0", 0, 14'h2001);
        serve("rr1", 1, 14'h3FFF);
        serve("rr2", 2, 14'h0000);
        serve("rr3", 3, 14'h1FFF);
        serve("rr4", 0, 14'h2001);
        bus.req = 4'b0000;
        tick();
        tick();
        check("rr idle", 32'(bus.busy), 32'h0);

        // 4. Reset five cycles into SETTLE: immediate reset values, no ack.
        set_code(2, 14'h1234);
        bus.req = 4'b0100;
        wait_valid("abort", n);
        check("abort data", 32'(bus.dac_data), 32'h3234);
        check("abort sel", 32'(bus.dac_sel), 32'h2);
        repeat (5) tick();
        snap = ack_count;
        rst_n = 1'b0;
        #1;
        check("abort dac_data", 32'(bus.dac_data), 32'h0);
        check("abort dac_sel", 32'(bus.dac_sel), 32'h0);
        check("abort busy", 32'(bus.busy), 32'h0);
        check("abort dac_valid", 32'(bus.dac_valid), 32'h0);
        check("abort ack", 32'(bus.ack), 32'h0);
        bus.req = 4'b0000;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (25) tick();
        check("abort no ack", ack_count - snap, 32'd0);
        check("abort idle", 32'(bus.busy), 32'h0);

        // 5. req[3] withdrawn before GRANT, req[2] withdrawn after GRANT.
        set_code(2, 14'h2ABC);
        set_code(3, 14'h1111);
        bus.req = 4'b1100;
        tick();
        bus.req = 4'b0100;
        tick();
        bus.req = 4'b0000;
        set_code(2, 14'h3FFF);
        tick();
        check("withdraw valid", 32'(bus.dac_valid), 32'h1);
        check("withdraw sel", 32'(bus.dac_sel), 32'h2);
        check("withdraw data latched", 32'(bus.dac_data), 32'h0ABC);
        wait_ack("withdraw", 2);
        snap = valid_count;
        repeat (25) tick();
        check("withdraw req3 skipped", valid_count - snap, 32'd0);
        check("withdraw idle", 32'(bus.busy), 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dac_update_scheduler.md
Name: dac_update_scheduler

Overview:
- Shares one 14-bit DAC channel between N SPGD requesters (perturbation and actuator-update sources).
- Arbitrates round-robin, converts the winner's offset-binary word to two's complement, and drives the DAC.
- Holds each code for a programmable settle time, then acknowledges the requester.
- Sits between the SPGD update logic and the DAC output register.

Parameters:
- WIRE_WIDTH, 14, DAC data width in bits.
- N_REQ, 4, number of requesters (2..8).
- SETTLE_CYCLES, 16, clock cycles each code is held before ack (>=1).
- MAX_STEP, 14'h0100, largest code change per settle period, in offset-binary LSBs. Used only with the optional feature.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N_REQ  per-requester update request, level, held until ack.
- data_in  input  N_REQ*WIRE_WIDTH  offset-binary codes; requester i uses bits [i*W +: W].
- ack  output  N_REQ  one-cycle pulse to the granted requester when its code has settled.
- dac_data  output  WIRE_WIDTH  two's-complement code to the DAC register.
- dac_valid  output  1  one-cycle strobe when dac_data changes.
- dac_sel  output  clog2(N_REQ)  index of the currently granted requester.
- busy  output  1  high in any state other than IDLE.

Behaviour:
Clock, reset and conversion
- One clock: clk. Reset: rst_n, asynchronous, active-low.
- Reset values:
  - dac_data = 0 (midscale).
  - dac_valid = 0, ack = 0, dac_sel = 0, busy = 0.
  - Round-robin pointer = 0.
  - Internal last-code register = 14'h2000 (offset-binary midscale).
- Conversion: dac_data = offset code with its MSB inverted, e.g. 14'h0000 -> 14'h2000, 14'h2000 -> 14'h0000, 14'h3FFF -> 14'h1FFF.

FSM states: IDLE, GRANT, LOAD, SETTLE, ACK.
- IDLE: if any req is high, go to GRANT; otherwise stay.
- GRANT (1 cycle):
  - Pick the first high req at or after the pointer, wrapping modulo N_REQ.
  - Latch its index into dac_sel and its data_in into a target register. data_in may change after GRANT.
- LOAD (1 cycle):
  - Register the converted code into dac_data and pulse dac_valid.
  - Reload the settle counter with SETTLE_CYCLES-1.
- SETTLE: decrement the counter; at 0 go to ACK.
- ACK (1 cycle):
  - Pulse ack[dac_sel].
  - Set pointer = dac_sel+1, wrapping to 0.
  - Go to IDLE.

Latency and fairness
- Request to dac_valid: 3 cycles (IDLE, GRANT, LOAD).
- Request to ack: SETTLE_CYCLES+3 cycles.
- Requester i waits at most N_REQ-1 other services.
- The requester just served has lowest priority next round.

Boundary conditions
- Simultaneous requests: the pointer decides. No request is lost while its req stays high.
- req dropped after GRANT: the transaction still completes, including the ack pulse.
- req dropped before GRANT: not served.
- Same code as the current output: LOAD still strobes dac_valid and the full settle time is still applied.
- Reset asserted mid-operation:
  - Immediate return to IDLE with all outputs at their reset values.
  - No ack is issued for the aborted transaction.
- A requester holding req high after its ack is re-arbitrated normally; the rotated pointer prevents starvation of others.

Optional Feature:
Macro: DAC_SLEW_LIMIT_EN

With the macro defined:
- LOAD moves the last-code register toward the target by at most MAX_STEP, in offset-binary, unsigned compare.
- If the target is still not reached after SETTLE, return to LOAD instead of ACK. Each intermediate step strobes dac_valid and settles fully.
- ack is issued only once the target is reached.
- Steps never overshoot or wrap past 14'h0000 or 14'h3FFF.

Without the macro:
- LOAD applies the target directly.
- MAX_STEP is ignored.
- Behaviour is exactly as above.

Decomposition:
- Shared package spgd_dac_pkg:
  - Default DAC width constant of 14.
  - Offset-binary midscale constant 14'h2000.
  - FSM state enum.
  - Function for the requester-index width, clog2(N_REQ).
- One sub-module: offset_to_twos. A pure combinational MSB inversion of WIRE_WIDTH bits, instantiated on the LOAD path.

Test Plan:
1. Reset: hold rst_n low, then release. dac_data=0, dac_valid=0, ack=0, busy=0. No activity without req.
2. Single request:
   - Stimulus: req[1]=1 with code 14'h0000.
   - Response: dac_valid after 3 cycles with dac_data=14'h2000 and dac_sel=1. ack[1] pulses at cycle 19 (SETTLE_CYCLES=16).
3. All requests high at once:
   - Stimulus: req=4'b1111 with codes 14'h0001, 14'h1FFF, 14'h2000, 14'h3FFF.
   - Response: service order 0,1,2,3,0 and dac_data 14'h2001, 14'h3FFF, 14'h0000, 14'h1FFF.
4. Reset mid-SETTLE: assert rst_n low 5 cycles after dac_valid. Outputs return to reset values immediately and no ack is issued.
5. Request withdrawal: drop req[2] one cycle after GRANT. The code is still driven and ack[2] still pulses. A req[3] dropped before GRANT is skipped.
6. DAC_SLEW_LIMIT_EN defined:
   - Stimulus: MAX_STEP=14'h0100, midscale to target 14'h2300.
   - Response: three dac_valid strobes at offset codes 14'h2100, 14'h2200, 14'h2300 (dac_data 14'h0100, 14'h0200, 14'h0300). A single ack after the third settle.
